// File: rtl/tick_bcd_counter_if.sv
// Handshake-free signal bundle between the tick_bcd_counter and its environment.
// The master drives the tick/run/clear controls; the slave returns the count and display drive.
interface tick_bcd_counter_if;
    logic        tick_in;
    logic        run;
    logic        clear;
    logic [15:0] bcd;
    logic        carry;
    logic [6:0]  seg;
    logic [3:0]  an;

    modport master (
        output tick_in, run, clear,
        input  bcd, carry, seg, an
    );

    modport slave (
        input  tick_in, run, clear,
        output bcd, carry, seg, an
    );
endinterface

// File: rtl/tick_bcd_counter.sv
// Four-digit BCD counter of divider tick rising edges, sampled as data in the clk domain,
// with a multiplexed common-anode seven-segment scan.
module tick_bcd_counter #(
    parameter int SCAN_DIV = 16
) (
    input  logic               clk,
    input  logic               reset,
    tick_bcd_counter_if.slave  bus
);

    localparam logic [15:0] LP_LAST = 16'(SCAN_DIV - 1);

    logic        r_tick_q;
    logic [15:0] r_bcd;
    logic        r_carry;
    logic [15:0] r_scan_cnt;
    logic [1:0]  r_idx;
    logic [3:0]  r_an;
    logic [6:0]  r_seg;

    logic        w_rise;
    logic [15:0] w_next;
    logic        w_wrap;
    logic [3:0]  w_digit;
    logic [6:0]  w_pattern;

    assign w_rise = bus.tick_in & ~r_tick_q;

    // Ripple the increment upward; w_wrap survives only if every digit was 9.
    always_comb begin
        w_next = r_bcd;
        w_wrap = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_wrap) begin
                if (r_bcd[4*i +: 4] >= 4'd9) begin
                    w_next[4*i +: 4] = 4'd0;
                end else begin
                    w_next[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
                    w_wrap = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tick_q <= 1'b1;
            r_bcd    <= '0;
            r_carry  <= 1'b0;
        end else begin
            r_tick_q <= bus.tick_in;
            if (bus.clear) begin
                r_bcd   <= '0;
                r_carry <= 1'b0;
            end else if (w_rise && bus.run) begin
                r_bcd   <= w_next;
                r_carry <= w_wrap;
            end else begin
                r_carry <= 1'b0;
            end
        end
    end

    assign w_digit = r_bcd[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_pattern = 7'b1111111;
        case (w_digit)
            4'd0: w_pattern = 7'b1000000;
            4'd1: w_pattern = 7'b1111001;
            4'd2: w_pattern = 7'b0100100;
            4'd3: w_pattern = 7'b0110000;
            4'd4: w_pattern = 7'b0011001;
            4'd5: w_pattern = 7'b0010010;
            4'd6: w_pattern = 7'b0000010;
            4'd7: w_pattern = 7'b1111000;
            4'd8: w_pattern = 7'b0000000;
            4'd9: w_pattern = 7'b0010000;
            default: w_pattern = 7'b1111111;
        endcase
    end

    // Display drive lags idx by one edge so an and seg always switch together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd0;
            r_an       <= 4'b1110;
            r_seg      <= 7'b1000000;
        end else begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_pattern;
            if (r_scan_cnt == LP_LAST) begin
                r_scan_cnt <= '0;
                r_idx      <= r_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 16'd1;
            end
        end
    end

    assign bus.bcd   = r_bcd;
    assign bus.carry = r_carry;
    assign bus.seg   = r_seg;
    assign bus.an    = r_an;

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Scoreboard bench for tick_bcd_counter: an arithmetic reference model
// predicts every cycle's outputs, a negedge monitor compares them.
module tb_tick_bcd_counter;

    localparam int SD = 4;

    typedef struct packed {
        logic [15:0] bcd;
        logic        carry;
        logic [6:0]  seg;
        logic [3:0]  an;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    tick_bcd_counter_if bus ();

    tick_bcd_counter #(.SCAN_DIV(SD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    int m_cnt = 0;
    int m_tq  = 1;
    int m_t   = 0;

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'((n / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [15:0] act,
                         input logic [15:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference model: one clk edge with the inputs the bench applied.
    task automatic model(input logic r, input logic t, input logic ru,
                         input logic c);
        exp_t e;
        int idx;
        int dig;
        if (!r) begin
            m_cnt = 0;
            m_tq  = 1;
            m_t   = 0;
            e.bcd = '0;
            e.carry = 1'b0;
            e.an  = 4'b1110;
            e.seg = 7'b1000000;
        end else begin
            m_t++;
            idx = ((m_t - 1) / SD) % 4;
            dig = m_cnt;
            for (int i = 0; i < idx; i++) dig = dig / 10;
            dig = dig % 10;
            e.an  = ~(4'b0001 << idx);
            e.seg = seg_tab[dig];
            e.carry = 1'b0;
            if (c) begin
                m_cnt = 0;
            end else if (t && m_tq == 0 && ru) begin
                e.carry = (m_cnt == 9999);
                m_cnt = (m_cnt + 1) % 10000;
            end
            m_tq  = t ? 1 : 0;
            e.bcd = to_bcd(m_cnt);
        end
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            check("bcd", bus.bcd, e.bcd);
            check("carry", 16'(bus.carry), 16'(e.carry));
            check("seg", 16'(bus.seg), 16'(e.seg));
            check("an", 16'(bus.an), 16'(e.an));
        end
    end

    task automatic step(input logic r, input logic t, input logic ru,
                        input logic c);
        reset       = r;
        bus.tick_in = t;
        bus.run     = ru;
        bus.clear   = c;
        @(posedge clk);
        model(r, t, ru, c);
        #1;
    endtask

    task automatic pulses(input int n, input int hi, input int lo);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < hi; j++) step(1, 1, 1, 0);
            for (int j = 0; j < lo; j++) step(1, 0, 1, 0);
        end
    endtask

    initial begin
        int guard;
        reset = 1'b0;
        bus.tick_in = 1'b1;
        bus.run = 1'b1;
        bus.clear = 1'b0;
        #2;

        for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
        check("rst_an", 16'(bus.an), 16'h000e);
        check("rst_seg", 16'(bus.seg), 16'h0040);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0);
        check("held_high", bus.bcd, 16'h0000);
        for (int i = 0; i < 1001; i++) step(1, 0, 1, 0);

        pulses(12, 1001, 1001);
        check("twelve", bus.bcd, 16'h0012);

        step(1, 0, 1, 1);
        pulses(9999, 1, 1);
        check("preload", bus.bcd, 16'h9999);
        step(1, 1, 1, 0);
        check("wrap_bcd", bus.bcd, 16'h0000);
        check("wrap_cy", 16'(bus.carry), 16'h0001);
        step(1, 0, 1, 0);
        check("cy_end", 16'(bus.carry), 16'h0000);

        pulses(9999, 1, 1);
        step(1, 1, 1, 1);
        check("clr_rise", bus.bcd, 16'h0000);
        check("clr_cy", 16'(bus.carry), 16'h0000);
        step(1, 0, 1, 0);
        pulses(3, 1, 1);
        for (int k = 0; k < 5; k++) begin
            step(1, 1, 0, 0);
            step(1, 0, 0, 0);
        end
        check("run_off", bus.bcd, 16'h0003);

        step(1, 0, 1, 1);
        pulses(1234, 1, 1);
        for (int i = 0; i < 40; i++) step(1, 0, 1, 0);
        check("hold1234", bus.bcd, 16'h1234);

        step(1, 0, 1, 1);
        pulses(507, 1, 1);
        guard = 0;
        while (((m_t / SD) % 4) != 2 && guard < 20) begin
            step(1, 0, 1, 0);
            guard++;
        end
        check("idx2_seen", 16'(guard < 20), 16'h0001);
        step(0, 1, 1, 0);
        check("mid_rst_an", 16'(bus.an), 16'h000e);
        check("mid_rst_bcd", bus.bcd, 16'h0000);
        for (int i = 0; i < 12; i++) step(1, 1, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            step(logic'($urandom_range(0, 199) != 0),
                 logic'($urandom_range(0, 2) != 0),
                 logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 49) == 0));
        end

        @(negedge clk);
        #1;
        check("q_drained", 16'(q.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
